dm_access_unit: RTL and testbench

- Data-memory responder for the decoder's memory-control outputs (MemRead/MemWrite/MemWriteOp/MemReadOp).
- Owns a word-wide data RAM. Executes lw/lb/lh/lbu and sw/sb/sh.
- Sub-word stores use read-modify-write. Sub-word loads are extracted and extended.
- Sits between the datapath's EX/MEM stage and the register write-back mux, with a valid/ready request channel and a valid/ready response channel.

---
 rtl/dm_access_unit.sv | 218 +++++++++++++++++++++
 tb/tb_dm_access_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// dm_access_unit: data-memory responder for lw/lb/lh/lbu and sw/sb/sh.
// A word-wide RAM behind a valid/ready request channel and a valid/ready
// response channel. Sub-word stores go through read-modify-write. Loads
// register the RAM word first, then register the extracted/extended value.
// Optional build macro: DM_MISALIGN_CHECK_EN adds a misalign output and
// turns misaligned word/half accesses into immediate error responses.
module dm_access_unit #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        mem_write_op,
  input  logic [2:0]        mem_read_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       rdata,
  output logic              busy
`ifdef DM_MISALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [2:0]        wop_reg;
  logic [2:0]        rop_reg;
  logic              is_write_reg;
  logic              rd_phase_reg;
  logic [31:0]       read_word_reg;
  logic [31:0]       rdata_reg;
  logic [31:0]       ram [DEPTH];

  logic              accept;
  logic [ADDR_W-3:0] word_addr;
  logic [IDX_W-1:0]  word_idx;
  logic [31:0]       ram_q;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_value;
  logic [31:0]       store_data;
  logic [3:0]        byte_en;
  logic [31:0]       merged_word;

  function automatic logic [1:0] wr_size(input logic [2:0] op);
    case (op)
      3'b001:  return SZ_BYTE;
      3'b010:  return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [1:0] rd_size(input logic [2:0] op);
    case (op)
      3'b001, 3'b011: return SZ_BYTE;
      3'b010:         return SZ_HALF;
      default:        return SZ_WORD;
    endcase
  endfunction

  assign accept    = (state_reg == IDLE) && req_valid && (mem_read || mem_write);
  assign word_addr = addr_reg[ADDR_W-1:2];
  assign word_idx  = IDX_W'(word_addr % (ADDR_W-2)'(DEPTH));
  assign ram_q     = ram[word_idx];

`ifdef DM_MISALIGN_CHECK_EN
  logic [1:0] in_size;
  logic       misaligned_in;
  logic       misalign_reg;
  // Alignment is judged on the incoming request so the accept edge can route it.
  assign in_size       = mem_write ? wr_size(mem_write_op) : rd_size(mem_read_op);
  assign misaligned_in = ((in_size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                         ((in_size == SZ_HALF) && addr[0]);
`endif

  // Lane selection on the registered RAM word (little-endian lanes).
  assign byte_sel = read_word_reg[{addr_reg[1:0], 3'b000} +: 8];
  assign half_sel = addr_reg[1] ? read_word_reg[31:16] : read_word_reg[15:0];

  // Load extraction: sign/zero extension according to the latched read op.
  always_comb begin
    load_value = read_word_reg;
    case (rop_reg)
      3'b001:  load_value = {{24{byte_sel[7]}}, byte_sel};
      3'b011:  load_value = {24'h0, byte_sel};
      3'b010:  load_value = {{16{half_sel[15]}}, half_sel};
      default: load_value = read_word_reg;
    endcase
  end

  // Store lane data replicated across lanes plus the lane enables to merge it.
  always_comb begin
    store_data = wdata_reg;
    byte_en    = 4'b1111;
    case (wr_size(wop_reg))
      SZ_BYTE: begin
        store_data = {4{wdata_reg[7:0]}};
        byte_en    = 4'b0001 << addr_reg[1:0];
      end
      SZ_HALF: begin
        store_data = {2{wdata_reg[15:0]}};
        byte_en    = addr_reg[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_data = wdata_reg;
        byte_en    = 4'b1111;
      end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged_word[8*gi +: 8] = byte_en[gi] ? store_data[8*gi +: 8]
                                                : read_word_reg[8*gi +: 8];
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic; loads spend two cycles in RD (RAM read, then extraction).
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
`ifdef DM_MISALIGN_CHECK_EN
          if (misaligned_in)                                  state_next = RESP;
          else if (mem_write && (wr_size(mem_write_op) == SZ_WORD)) state_next = WR;
          else                                                state_next = RD;
`else
          if (mem_write && (wr_size(mem_write_op) == SZ_WORD)) state_next = WR;
          else                                                 state_next = RD;
`endif
        end
      end
      RD:      state_next = is_write_reg ? WR : (rd_phase_reg ? RESP : RD);
      WR:      state_next = RESP;
      RESP:    state_next = resp_ready ? IDLE : RESP;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state and registered data only.
  always_comb begin
    req_ready  = (state_reg == IDLE);
    busy       = (state_reg != IDLE);
    resp_valid = (state_reg == RESP);
    rdata      = rdata_reg;
  end

`ifdef DM_MISALIGN_CHECK_EN
  assign misalign = misalign_reg;
`endif

  // Request capture, RAM access and response data; reset wipes the whole RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wop_reg       <= '0;
      rop_reg       <= '0;
      is_write_reg  <= 1'b0;
      rd_phase_reg  <= 1'b0;
      read_word_reg <= '0;
      rdata_reg     <= '0;
`ifdef DM_MISALIGN_CHECK_EN
      misalign_reg  <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            addr_reg     <= addr;
            wdata_reg    <= wdata;
            wop_reg      <= mem_write_op;
            rop_reg      <= mem_read_op;
            is_write_reg <= mem_write;
            rd_phase_reg <= 1'b0;
            rdata_reg    <= '0;
`ifdef DM_MISALIGN_CHECK_EN
            misalign_reg <= misaligned_in;
`endif
          end
        end
        RD: begin
          if (is_write_reg || !rd_phase_reg) begin
            read_word_reg <= ram_q;
            rd_phase_reg  <= !is_write_reg;
          end else begin
            rdata_reg     <= load_value;
            rd_phase_reg  <= 1'b0;
          end
        end
        WR:      ram[word_idx] <= merged_word;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Testbench for dm_access_unit: table of transactions checked through a
// scoreboard queue, plus hand-written reset, ignore and backpressure cases.
// Honours DM_MISALIGN_CHECK_EN when the design is built with it.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_write_op;
  logic [2:0]  mem_read_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] rdata;
  logic        busy;
`ifdef DM_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  dm_access_unit #(.DEPTH(1024), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_write_op (mem_write_op),
    .mem_read_op  (mem_read_op),
    .addr         (addr),
    .wdata        (wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .rdata        (rdata),
    .busy         (busy)
`ifdef DM_MISALIGN_CHECK_EN
    ,
    .misalign     (misalign)
`endif
  );

  typedef struct {
    bit          wr;
    logic [2:0]  wop;
    logic [2:0]  rop;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    bit          mis;
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    bit          mis;
  } exp_t;

  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t tbl[$];
  exp_t sb_q[$];
  exp_t bp_e;
  int   bp_lat;
  bit   seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit wr, input logic [2:0] wop, input logic [2:0] rop,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] exp, input bit mis, input int lat,
                              input string nm);
    vec_t v;
    v.wr = wr; v.wop = wop; v.rop = rop; v.a = a; v.d = d;
    v.exp = exp; v.mis = mis; v.lat = lat; v.name = nm;
    return v;
  endfunction

  // One complete transaction with resp_ready held high.
  task automatic xact(input vec_t v);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk({v.name, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    mem_write    = v.wr;
    mem_read     = !v.wr;
    mem_write_op = v.wop;
    mem_read_op  = v.rop;
    addr         = v.a;
    wdata        = v.d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    e.data = v.exp;
    e.mis  = v.mis;
    sb_q.push_back(e);
    lat = 0;
    while (!resp_valid && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({v.name, "_latency"}, 32'(lat), 32'(v.lat));
    e = sb_q.pop_front();
    chk({v.name, "_rdata"}, rdata, e.data);
`ifdef DM_MISALIGN_CHECK_EN
    chk({v.name, "_misalign"}, 32'(misalign), 32'(e.mis));
`endif
    $display("xact %-12s wr=%0d addr=%h wdata=%h rdata=%h lat=%0d", v.name, v.wr, v.a, v.d, rdata, lat);
    @(posedge clk); #1;
    chk({v.name, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_write_op = 3'b000; mem_read_op = 3'b000; addr = '0; wdata = '0;
    resp_ready = 1'b1;

    // Table: {wr, wop, rop, addr, wdata, expected rdata, misalign, latency, name}
    tbl.push_back(mk(1, 3'b000, 3'b000, 32'h10,   32'h12345678, 32'h0,        0, 1, "sw_10"));
    tbl.push_back(mk(0, 3'b000, 3'b000, 32'h10,   32'h0,        32'h12345678, 0, 2, "lw_10"));
    tbl.push_back(mk(1, 3'b000, 3'b000, 32'h20,   32'h11223344, 32'h0,        0, 1, "sw_20"));
    tbl.push_back(mk(1, 3'b001, 3'b000, 32'h21,   32'hFFFFFFAA, 32'h0,        0, 2, "sb_21"));
    tbl.push_back(mk(0, 3'b000, 3'b000, 32'h20,   32'h0,        32'h1122AA44, 0, 2, "lw_20a"));
    tbl.push_back(mk(1, 3'b010, 3'b000, 32'h22,   32'h1234BEEF, 32'h0,        0, 2, "sh_22"));
    tbl.push_back(mk(0, 3'b000, 3'b000, 32'h20,   32'h0,        32'hBEEFAA44, 0, 2, "lw_20b"));
    tbl.push_back(mk(1, 3'b000, 3'b000, 32'h30,   32'h80FF7F01, 32'h0,        0, 1, "sw_30"));
    tbl.push_back(mk(0, 3'b000, 3'b001, 32'h33,   32'h0,        32'hFFFFFF80, 0, 2, "lb_33"));
    tbl.push_back(mk(0, 3'b000, 3'b011, 32'h33,   32'h0,        32'h00000080, 0, 2, "lbu_33"));
    tbl.push_back(mk(0, 3'b000, 3'b010, 32'h32,   32'h0,        32'hFFFF80FF, 0, 2, "lh_32"));
    tbl.push_back(mk(0, 3'b000, 3'b001, 32'h30,   32'h0,        32'h00000001, 0, 2, "lb_30"));
    tbl.push_back(mk(0, 3'b000, 3'b011, 32'h31,   32'h0,        32'h0000007F, 0, 2, "lbu_31"));
    tbl.push_back(mk(0, 3'b000, 3'b010, 32'h30,   32'h0,        32'h00007F01, 0, 2, "lh_30"));
    tbl.push_back(mk(0, 3'b000, 3'b001, 32'h32,   32'h0,        32'hFFFFFFFF, 0, 2, "lb_32"));
    tbl.push_back(mk(0, 3'b000, 3'b111, 32'h10,   32'h0,        32'h12345678, 0, 2, "lw_op7"));
    tbl.push_back(mk(1, 3'b101, 3'b000, 32'h40,   32'hA5A5A5A5, 32'h0,        0, 1, "sw_op5"));
    tbl.push_back(mk(0, 3'b000, 3'b000, 32'h40,   32'h0,        32'hA5A5A5A5, 0, 2, "lw_40"));
    tbl.push_back(mk(1, 3'b000, 3'b000, 32'h1000, 32'hCAFEF00D, 32'h0,        0, 1, "sw_wrap"));
    tbl.push_back(mk(0, 3'b000, 3'b000, 32'h0,    32'h0,        32'hCAFEF00D, 0, 2, "lw_0"));
`ifdef DM_MISALIGN_CHECK_EN
    tbl.push_back(mk(0, 3'b000, 3'b000, 32'h2,    32'h0,        32'h0,        1, 0, "lw_mis2"));
    tbl.push_back(mk(0, 3'b000, 3'b000, 32'h0,    32'h0,        32'hCAFEF00D, 0, 2, "lw_0_again"));
    tbl.push_back(mk(1, 3'b000, 3'b000, 32'h41,   32'h5A5A5A5A, 32'h0,        1, 0, "sw_mis41"));
    tbl.push_back(mk(0, 3'b000, 3'b000, 32'h40,   32'h0,        32'hA5A5A5A5, 0, 2, "lw_40b"));
    tbl.push_back(mk(0, 3'b000, 3'b010, 32'h33,   32'h0,        32'h0,        1, 0, "lh_mis33"));
    tbl.push_back(mk(1, 3'b001, 3'b000, 32'h43,   32'h00000077, 32'h0,        0, 2, "sb_43"));
    tbl.push_back(mk(0, 3'b000, 3'b000, 32'h40,   32'h0,        32'h77A5A5A5, 0, 2, "lw_40c"));
`else
    tbl.push_back(mk(0, 3'b000, 3'b000, 32'h2,    32'h0,        32'hCAFEF00D, 0, 2, "lw_low2"));
    tbl.push_back(mk(1, 3'b000, 3'b000, 32'h41,   32'h5A5A5A5A, 32'h0,        0, 1, "sw_low41"));
    tbl.push_back(mk(0, 3'b000, 3'b000, 32'h40,   32'h0,        32'h5A5A5A5A, 0, 2, "lw_40b"));
    tbl.push_back(mk(0, 3'b000, 3'b010, 32'h33,   32'h0,        32'hFFFF80FF, 0, 2, "lh_low33"));
    tbl.push_back(mk(1, 3'b001, 3'b000, 32'h43,   32'h00000077, 32'h0,        0, 2, "sb_43"));
    tbl.push_back(mk(0, 3'b000, 3'b000, 32'h40,   32'h0,        32'h775A5A5A, 0, 2, "lw_40c"));
`endif

    // Reset state.
    #12;
    chk("rst_req_ready",  32'(req_ready),  32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata",      rdata,           32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // req_valid without read or write is ignored.
    @(negedge clk);
    req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ignore_busy",      32'(busy),      32'd0);
    chk("ignore_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    $display("xact %-12s req_valid with no kind, busy=%0d", "ignored", busy);

    // Reset during the RD phase of a byte store aborts it.
    @(negedge clk);
    req_valid = 1'b1; mem_write = 1'b1; mem_write_op = 3'b001; addr = 32'h8; wdata = 32'hAA;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_write = 1'b0;
    chk("rmw_busy_in_rd", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rmw_rst_busy",       32'(busy),       32'd0);
    chk("rmw_rst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    chk("rmw_no_resp_after_rst", 32'(seen), 32'd0);
    $display("xact %-12s reset in RD, response seen=%0d", "sb_abort", seen);
    xact(mk(0, 3'b000, 3'b000, 32'h8, 32'h0, 32'h0, 0, 2, "lw_8_clear"));

    // Table-driven transactions.
    for (int i = 0; i < tbl.size(); i++) xact(tbl[i]);

    // Backpressure: lw held in RESP for 5 cycles while another request waits.
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; mem_read = 1'b1; mem_read_op = 3'b000; addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_read = 1'b0;
    bp_e.data = 32'h12345678; bp_e.mis = 1'b0;
    sb_q.push_back(bp_e);
    bp_lat = 0;
    while (!resp_valid && bp_lat < 16) begin
      @(posedge clk); #1;
      bp_lat++;
    end
    chk("bp_latency", 32'(bp_lat), 32'd2);
    bp_e = sb_q.pop_front();
    @(negedge clk);
    req_valid = 1'b1; mem_write = 1'b1; mem_write_op = 3'b000; addr = 32'h10; wdata = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_rdata",      rdata,           bp_e.data);
      chk("bp_req_ready",  32'(req_ready),  32'd0);
    end
    $display("xact %-12s held 5 cycles rdata=%h", "lw_bp", rdata);
    @(negedge clk);
    mem_write = 1'b0; mem_read = 1'b1; mem_read_op = 3'b000; addr = 32'h20;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_resp_valid", 32'(resp_valid), 32'd0);
    chk("bp_release_req_ready",  32'(req_ready),  32'd1);
    @(posedge clk); #1;
    chk("bp_second_accepted", 32'(busy), 32'd1);
    req_valid = 1'b0; mem_read = 1'b0;
    bp_e.data = 32'hBEEFAA44; bp_e.mis = 1'b0;
    sb_q.push_back(bp_e);
    bp_lat = 0;
    while (!resp_valid && bp_lat < 16) begin
      @(posedge clk); #1;
      bp_lat++;
    end
    chk("bp2_latency", 32'(bp_lat), 32'd2);
    bp_e = sb_q.pop_front();
    chk("bp2_rdata", rdata, bp_e.data);
    $display("xact %-12s addr=00000020 rdata=%h lat=%0d", "lw_after_bp", rdata, bp_lat);
    @(posedge clk); #1;
    xact(mk(0, 3'b000, 3'b000, 32'h10, 32'h0, 32'h12345678, 0, 2, "lw_10_kept"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
